// File: rtl/mips_core_pkg.sv
// Shared arbiter types and constants for the memory-side egress arbiter.
// Optional round-robin arbitration is enabled with the ARB_ROUND_ROBIN_EN macro.
package mips_core_pkg;

  localparam int unsigned ARB_MAX_BEATS = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Grant id width; at least one bit so a single-master build still has a port.
  function automatic int unsigned arb_idw(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Bundle of the per-master request side and the registered egress channel.
// slave: the arbiter's view; master: the view of whoever drives masters and sinks beats.
interface rr_burst_arbiter_if
  import mips_core_pkg::*;
#(
  parameter int unsigned COUNT = 2,
  parameter int unsigned WIDTH = 32
);

  localparam int unsigned IDW = arb_idw(COUNT);

  logic                        ready;
  logic                        valid;
  logic [WIDTH-1:0]            payload;
  logic                        last;
  logic [IDW-1:0]              grant_id;
  logic                        err_overrun;
  logic [COUNT-1:0]            entity_ready;
  logic [COUNT-1:0]            entity_valid;
  logic [COUNT-1:0]            entity_last;
  logic [COUNT-1:0][WIDTH-1:0] entity_payload;

  modport slave (
    input  ready, entity_valid, entity_last, entity_payload,
    output valid, payload, last, grant_id, err_overrun, entity_ready
  );

  modport master (
    output ready, entity_valid, entity_last, entity_payload,
    input  valid, payload, last, grant_id, err_overrun, entity_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or above ptr, wrapping to 0.
module rr_pick
  import mips_core_pkg::*;
#(
  parameter int unsigned COUNT = 2,
  localparam int unsigned IDW = arb_idw(COUNT)
) (
  input  logic [COUNT-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id
);

  int unsigned idx;

  // Scan COUNT positions starting at ptr; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      idx = (32'(ptr) + i) % COUNT;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Egress arbiter: merges COUNT valid/ready masters onto one registered channel.
// Grant is locked from the first beat of a burst until its last beat is accepted.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins in idle.
module rr_burst_arbiter
  import mips_core_pkg::*;
#(
  parameter int unsigned COUNT     = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = ARB_MAX_BEATS
) (
  input logic               clk,
  input logic               rst_n,
  rr_burst_arbiter_if.slave bus
);

  localparam int unsigned IDW = arb_idw(COUNT);
  localparam int unsigned CW  = $clog2(MAX_BEATS + 1);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;
  logic             valid_q, last_q;
  logic [WIDTH-1:0] payload_q;
  logic [IDW-1:0]   grant_id_q;

  logic             adv, accept, beat_last;
  logic             pick_valid, gnt_valid;
  logic [IDW-1:0]   pick_id, gnt_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q;

  rr_pick #(.COUNT(COUNT)) u_pick (
    .req       (bus.entity_valid),
    .ptr       (ptr_q),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );

  // Pointer moves past the master whose burst just ended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && beat_last) begin
      ptr_q <= (gnt_id == IDW'(COUNT - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (!pick_valid && bus.entity_valid[i]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(i);
      end
    end
  end
`endif

  // While locked only the lock owner is eligible, even if it is not valid.
  always_comb begin
    gnt_valid = pick_valid;
    gnt_id    = pick_id;
    if (state_q == ARB_LOCKED) begin
      gnt_id    = lock_id_q;
      gnt_valid = bus.entity_valid[lock_id_q];
    end
  end

  assign adv       = bus.ready || !valid_q;
  assign accept    = rst_n && adv && gnt_valid;
  assign beat_last = bus.entity_last[gnt_id];

  // Ready only to the granted master; nothing is accepted while in reset.
  always_comb begin
    bus.entity_ready = '0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (IDW'(i) == gnt_id && (gnt_valid || state_q == ARB_LOCKED)) begin
        bus.entity_ready[i] = adv && rst_n;
      end
    end
  end

  // Burst lock FSM with saturating beat counter and sticky overrun flag.
  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept && !beat_last) begin
          state_d    = ARB_LOCKED;
          lock_id_d  = gnt_id;
          beat_cnt_d = CW'(1);
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          if (beat_last) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
          end else if (beat_cnt_q >= CW'(MAX_BEATS)) begin
            err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Output stage: loads on acceptance, empties when drained, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      payload_q  <= '0;
      last_q     <= 1'b0;
      grant_id_q <= '0;
    end else if (adv) begin
      valid_q <= accept;
      if (accept) begin
        payload_q  <= bus.entity_payload[gnt_id];
        last_q     <= beat_last;
        grant_id_q <= gnt_id;
      end
    end
  end

  assign bus.valid       = valid_q;
  assign bus.payload     = payload_q;
  assign bus.last        = last_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.err_overrun = err_q;

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Parametrised egress arbiter merging COUNT valid/ready masters onto one registered valid/ready channel, with round-robin fairness and burst locking. Grant is held from the first beat of a burst until its LAST beat is accepted, so it can drive both AXI address channels (single-beat) and the AXI write-data channel (multi-beat) without interleaving. It sits in the memory arbiter between the cache masters and the external AXI interface, and adds one cycle of latency.

## Interface
- COUNT, 2, number of masters (≥1)
- WIDTH, 32, payload width in bits
- MAX_BEATS, 8, longest legal burst in beats
- IDW, derived as max(1, $clog2(COUNT)), grant id width (localparam, not overridable)

- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- ready  in  1  downstream accepts the output beat
- valid  out  1  output beat valid
- payload  out  WIDTH  output beat data
- last  out  1  output beat ends its burst
- grant_id  out  IDW  index of the master that sourced the output beat
- err_overrun  out  1  sticky; a burst exceeded MAX_BEATS
- entity_ready  out  [COUNT]  per-master ready
- entity_valid  in  [COUNT]  per-master valid
- entity_last  in  [COUNT]  per-master last; tie to 1 for single-beat channels
- entity_payload  in  [COUNT][WIDTH]  per-master data

## Operation
- Output stage is one register. Define adv = ready || !valid. A beat transfers from master g when adv && entity_valid[g] && g is the granted master.
- Beats are accepted in the same cycle they are granted; entity_ready[g] = adv for the granted master, 0 for all others.
- State machine:
  - IDLE: grant the first valid master found scanning upward from ptr, wrapping at COUNT-1 to 0. If the accepted beat has entity_last=0, latch lock_id=g, set beat_cnt=1, and go to LOCKED.
  - LOCKED: only lock_id is eligible. Every other master sees ready=0, even while lock_id is not valid (this produces a bubble, not a re-grant). Each accepted beat increments beat_cnt. An accepted beat with entity_last=1 returns the FSM to IDLE.
- ptr update: on acceptance of any beat with entity_last=1, ptr <= (g == COUNT-1) ? 0 : g+1. ptr is unchanged otherwise.
- On acceptance, the register loads payload, last and grant_id, and valid <= 1. When adv=1 and no beat is accepted, valid <= 0. When adv=0, the register holds.
- Overrun: when beat_cnt reaches MAX_BEATS in LOCKED and a further beat is accepted without last, err_overrun <= 1. The lock is kept. beat_cnt saturates and never wraps.
- COUNT=1: ptr is constant 0 and grant_id is constant 0.

## Timing
- Reset values: valid=0, payload='0, last=0, grant_id=0, err_overrun=0, state IDLE, ptr=0, beat_cnt=0.
- Latency: a beat accepted in cycle N appears on the output in cycle N+1.
- Throughput: one beat per cycle while ready=1.
- Once valid=1, payload, last and grant_id hold stable until ready=1.
- entity_ready is combinational in ready, valid, state and entity_valid. There is no combinational path from ready to the output valid.
- Simultaneous requests in IDLE: ptr decides. The last beat of a burst and a new grant to another master may occur in back-to-back cycles with no bubble.
- Reset asserted mid-burst: all state returns to the reset values at the next clk edge. An in-flight output beat is dropped and lock is lost.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin via ptr, as described above.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins in IDLE. The ptr register is not built. Burst locking and overrun detection are unchanged.

## Structure
- mips_core_pkg: ARB_MAX_BEATS = 8 (default for MAX_BEATS) and typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
- Sub-module rr_pick (combinational): inputs req[COUNT] and ptr; outputs gnt_valid and gnt_id (the first request at or above ptr, with wrap). It is instantiated only under ARB_ROUND_ROBIN_EN.

## Test plan
- Reset check: hold rst_n=0 with all entity_valid=1 → valid=0, err_overrun=0, entity_ready all 0 after the reset edge. Release reset, ready=1 → master 0 accepted first; valid=1 one cycle later with grant_id=0.
- Fairness: COUNT=3, all masters valid with last=1 continuously, ready=1 → grant_id sequence 0,1,2,0,1,2. Without ARB_ROUND_ROBIN_EN → 0,0,0,….
- Burst lock: master 1 sends 4 beats (last on beat 4) while master 0 is valid, ready=1 → output shows grant_id 1 for 4 consecutive beats, then grant_id=0. entity_ready[0]=0 throughout the burst.
- Bubble in lock: master 1 deasserts valid for 2 cycles mid-burst → valid=0 for 2 cycles, master 0 is not granted, and the burst then completes.
- Backpressure: ready=0 for 3 cycles with output valid=1 → payload stable, all entity_ready=0, no beat lost or duplicated.
- Overrun and reset: MAX_BEATS=8, master 0 sends 9 beats with last=0 → err_overrun=1 from the cycle after the 9th acceptance. Pulse rst_n=0 mid-burst → err_overrun=0, state IDLE, and master 1 can be granted immediately.
